// File: rtl/hazard_ctrl.sv
// hazard_ctrl: prioritised pipeline enable/flush control with a data-memory watchdog.
// Define HAZARD_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load_use,
    input  logic        i_redirect_execute,
    input  logic        i_mem_req,
    input  logic        i_mem_ack,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_en,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_flush,
    output logic        o_halt,
    output logic        o_mem_fault,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
    state_t state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic mem_stall, halted, flow;
    assign mem_stall = i_mem_req & ~i_mem_ack;
    assign halted    = state == HALT;
    assign flow      = ~halted & ~mem_stall;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            o_mem_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            o_mem_fault <= ~halted & (state_nxt == HALT);
        end
    end
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        if (!halted) begin
            state_nxt    = !mem_stall ? RUN : (wait_cnt == 8'(MEM_TIMEOUT - 1)) ? HALT : MEM_WAIT;
            wait_cnt_nxt = (mem_stall && state_nxt != HALT) ? wait_cnt + 8'd1 : 8'd0;
        end
    end
    // A redirect overrides load-use: the stalled decode instruction is on the wrong path.
    assign o_pc_en        = flow & (i_redirect_execute | ~i_load_use);
    assign o_if_id_en     = o_pc_en;
    assign o_if_id_flush  = halted | (flow & i_redirect_execute);
    assign o_id_ex_en     = flow;
    assign o_id_ex_flush  = halted | (flow & (i_redirect_execute | i_load_use));
    assign o_ex_mem_en    = flow;
    assign o_mem_wb_flush = ~flow;
    assign o_halt         = halted;
`ifdef HAZARD_CTRL_PERF_EN
    logic stall_hit, flush_hit;
    assign stall_hit = ~halted & (mem_stall | (i_load_use & ~i_redirect_execute));
    assign flush_hit = flow & i_redirect_execute;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stall_cycles <= '0;
            o_flush_count  <= '0;
        end else begin
            o_stall_cycles <= o_stall_cycles + {31'd0, stall_hit & ~&o_stall_cycles};
            o_flush_count  <= o_flush_count + {31'd0, flush_hit & ~&o_flush_count};
        end
    end
`else
    assign o_stall_cycles = '0;
    assign o_flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with a reference model of the watchdog and counters.
module tb_hazard_ctrl;
    localparam int TO = 4;
    logic i_clk = 1'b0, i_reset = 1'b1;
    logic i_load_use = 1'b0, i_redirect_execute = 1'b0, i_mem_req = 1'b0, i_mem_ack = 1'b0;
    logic o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush, o_ex_mem_en, o_mem_wb_flush;
    logic o_halt, o_mem_fault;
    logic [31:0] o_stall_cycles, o_flush_count;
    int checks = 0, failures = 0;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;
    exp_t q[$];
    exp_t e;

    logic m_halt, m_fault;
    int m_cnt;
    logic [31:0] m_sc, m_fc;

    hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_load_use(i_load_use),
        .i_redirect_execute(i_redirect_execute), .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
        .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
        .o_id_ex_en(o_id_ex_en), .o_id_ex_flush(o_id_ex_flush), .o_ex_mem_en(o_ex_mem_en),
        .o_mem_wb_flush(o_mem_wb_flush), .o_halt(o_halt), .o_mem_fault(o_mem_fault),
        .o_stall_cycles(o_stall_cycles), .o_flush_count(o_flush_count)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_halt <= 1'b0; m_fault <= 1'b0; m_cnt <= 0; m_sc <= 0; m_fc <= 0;
        end else if (m_halt) begin
            m_fault <= 1'b0;
        end else begin
            m_fault <= 1'b0;
            if (i_mem_req && !i_mem_ack) begin
                m_sc <= m_sc + 1;
                if (m_cnt == TO - 1) begin
                    m_halt <= 1'b1; m_fault <= 1'b1;
                end else m_cnt <= m_cnt + 1;
            end else begin
                m_cnt <= 0;
                if (i_redirect_execute) m_fc <= m_fc + 1;
                else if (i_load_use) m_sc <= m_sc + 1;
            end
        end
    end

    // order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush
    function automatic logic [6:0] ctl_model(input logic h, lu, rd, req, ack);
        if (h) return 7'b0010101;
        if (req && !ack) return 7'b0000001;
        if (rd) return 7'b1111110;
        if (lu) return 7'b0001110;
        return 7'b1101010;
    endfunction

    task automatic drive(input logic lu, rd, req, ack);
        exp_t x;
        i_load_use = lu; i_redirect_execute = rd; i_mem_req = req; i_mem_ack = ack;
        x.ctl = {ctl_model(m_halt, lu, rd, req, ack), m_halt, m_fault};
`ifdef HAZARD_CTRL_PERF_EN
        x.sc = m_sc; x.fc = m_fc;
`else
        x.sc = 0; x.fc = 0;
`endif
        q.push_back(x);
    endtask

    function automatic logic [8:0] ctl_now();
        return {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush, o_ex_mem_en,
                o_mem_wb_flush, o_halt, o_mem_fault};
    endfunction

    task automatic test_reset();
        drive(0, 0, 0, 0);
        #2;
        e = q.pop_front();
        checks++;
        if (ctl_now() !== 9'b110101000 || ctl_now() !== e.ctl) begin
            failures++; $display("FAIL reset_ctl got=%b want=%b", ctl_now(), e.ctl);
        end
        checks++;
        if (o_stall_cycles !== 0 || o_flush_count !== 0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", o_stall_cycles, o_flush_count);
        end
        @(posedge i_clk); #1 i_reset = 1'b0;
    endtask

    task automatic run_seq(input string name, input logic [3:0] seq[$]);
        foreach (seq[i]) begin
            drive(seq[i][3], seq[i][2], seq[i][1], seq[i][0]);
            @(negedge i_clk);
            e = q.pop_front();
            checks++;
            if (ctl_now() !== e.ctl) begin
                failures++; $display("FAIL %s[%0d] ctl got=%b want=%b", name, i, ctl_now(), e.ctl);
            end
            checks++;
            if (o_stall_cycles !== e.sc || o_flush_count !== e.fc) begin
                failures++;
                $display("FAIL %s[%0d] counters got=%0d/%0d want=%0d/%0d", name, i,
                         o_stall_cycles, o_flush_count, e.sc, e.fc);
            end
            @(posedge i_clk); #1;
        end
    endtask

    // bits: {load_use, redirect, mem_req, mem_ack}
    task automatic test_load_use();
        run_seq("load_use", '{4'b0000, 4'b1000, 4'b0000, 4'b0000});
    endtask

    task automatic test_redirect_over_load_use();
        run_seq("redirect_lu", '{4'b1100, 4'b0000, 4'b0001});
    endtask

    task automatic test_redirect_during_stall();
        run_seq("redirect_stall", '{4'b0110, 4'b0110, 4'b0111, 4'b0000, 4'b0010, 4'b0000});
    endtask

    task automatic pulse_reset(input string name);
        i_load_use = 0; i_redirect_execute = 0; i_mem_req = 0; i_mem_ack = 0;
        i_reset = 1'b1;
        #2;
        checks++;
        if (ctl_now() !== 9'b110101000) begin
            failures++; $display("FAIL %s ctl got=%b want=110101000", name, ctl_now());
        end
        checks++;
        if (o_stall_cycles !== 0 || o_flush_count !== 0) begin
            failures++; $display("FAIL %s counters got=%0d/%0d want=0/0", name, o_stall_cycles, o_flush_count);
        end
        i_reset = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        run_seq("pre_reset_wait", '{4'b0010, 4'b0010});
        pulse_reset("reset_mid_wait");
        run_seq("post_reset_wait", '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000});
    endtask

    task automatic test_watchdog();
        run_seq("watchdog", '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                              4'b0011, 4'b1100, 4'b0000});
        pulse_reset("reset_from_halt");
        run_seq("after_halt", '{4'b0000, 4'b1000, 4'b0000});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_redirect_over_load_use();
        test_redirect_during_stall();
        test_reset_mid_wait();
        test_watchdog();
        checks++;
        if (q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline hazard controller for the 5-stage RV32I core. Takes the per-cycle hazard requests (load-use stall from the decode-stage load detector, taken-branch/jump redirect from execute, data-memory wait from the MEM stage) and produces one prioritised set of enable/flush controls for PC and every pipeline register. A data-memory watchdog halts the core if an access never completes.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive memory-stall cycles tolerated before halting (legal range 2..255).

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  asynchronous, active-high reset
- i_load_use  in  1  load-use hazard detected for the instruction in decode
- i_redirect_execute  in  1  branch taken or jump resolved in execute; PC loads target this cycle
- i_mem_req  in  1  MEM-stage instruction is a load/store awaiting data memory
- i_mem_ack  in  1  data memory completes the access this cycle
- o_pc_en  out  1  PC register update enable
- o_if_id_en  out  1  IF/ID register enable
- o_if_id_flush  out  1  IF/ID load bubble (NOP)
- o_id_ex_en  out  1  ID/EX register enable
- o_id_ex_flush  out  1  ID/EX load bubble
- o_ex_mem_en  out  1  EX/MEM register enable
- o_mem_wb_flush  out  1  MEM/WB load bubble
- o_halt  out  1  core halted by memory watchdog
- o_mem_fault  out  1  one-cycle pulse on watchdog expiry
- o_stall_cycles  out  32  stall-cycle performance counter
- o_flush_count  out  32  redirect-flush performance counter

## Operation
- States: RUN (wait_cnt==0), MEM_WAIT (wait_cnt>0), HALT.
- mem_stall = i_mem_req & ~i_mem_ack, combinational.
- Control decode (Mealy, same cycle), priority HALT > mem_stall > redirect > load-use:
  - HALT: all enables 0, all flushes 1, o_halt=1.
  - mem_stall: o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en = 0; o_mem_wb_flush=1; other flushes 0.
  - redirect: all enables 1; o_if_id_flush=1, o_id_ex_flush=1. A simultaneous i_load_use is ignored (wrong-path instruction).
  - load-use: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; others enabled, no other flush.
  - none: all enables 1, all flushes 0.
- Redirect asserted during a memory stall is not lost: EX is frozen, so the request persists and applies in the first non-stalled cycle.
- Watchdog: on each edge with mem_stall, if wait_cnt==MEM_TIMEOUT-1 go to HALT and assert o_mem_fault next cycle, else wait_cnt+1. Clock edge without mem_stall (not HALT): wait_cnt=0, state RUN.
- HALT is left only via i_reset; inputs ignored there.

## Timing
- Reset (async, immediate): state RUN, wait_cnt 0, o_halt 0, o_mem_fault 0, counters 0. With idle inputs, outputs: all enables 1, all flushes 0.
- Control outputs: zero latency from inputs/state. o_halt, o_mem_fault, counters: registered, one cycle.
- o_mem_fault high exactly one cycle: the first HALT cycle.
- i_mem_ack with i_mem_req=0: ignored. Ack in the same cycle as req: no stall.
- Reset mid-MEM_WAIT or in HALT: returns to RUN next cycle after deassertion, no fault pulse.

## Configuration
- HAZARD_CTRL_PERF_EN defined: o_stall_cycles +1 each cycle mem_stall or load-use stall is applied (not in HALT); o_flush_count +1 each cycle a redirect is applied. Both saturate at 32'hFFFF_FFFF.
- Not defined: counters absent, both ports tied 0. Hazard control unaffected.

## Test plan
- Reset, idle inputs -> all enables 1, all flushes 0, o_halt 0, counters 0.
- i_load_use=1 one cycle -> that cycle o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; next cycle all enabled; o_stall_cycles=1 (PERF_EN).
- i_load_use=1 and i_redirect_execute=1 together -> o_pc_en=1, o_if_id_flush=1, o_id_ex_flush=1; o_flush_count=1, o_stall_cycles=0.
- i_mem_req=1 3 cycles, i_mem_ack=1 in 3rd, redirect high throughout -> 2 cycles frozen with o_mem_wb_flush=1, redirect applied in cycle 3, wait_cnt back to 0, no fault.
- MEM_TIMEOUT=4, i_mem_req=1, i_mem_ack=0 held -> 4 frozen cycles, cycle 5 o_halt=1 and o_mem_fault=1, cycle 6 o_mem_fault=0 with o_halt=1; late i_mem_ack ignored; i_reset restores RUN.
- i_reset pulsed during MEM_WAIT (wait_cnt=2) -> immediate RUN decode, no o_mem_fault, new stall restarts count from 0.
